prog_clk_div: RTL and testbench
===============================

# prog_clk_div

Programmable, glitch-free clock divider/duty-cycle generator driven by the system clock. It produces a divided output whose period and high time come from one of three compile-time presets or one runtime-loadable slot. A selection change is adopted only at a period boundary, so the output never shows a truncated or runt phase. It sits between the board oscillator and the display/buzzer/LED consumers that need selectable low-rate clocks or enables.

## Interface
- CNT_W, 16: width of counter, period and high-time values
- P0_PER, 4245: slot 0 period in clk_in cycles
- P0_HI, 849: slot 0 high time in cycles
- P1_PER, 28121: slot 1 period
- P1_HI, 5625: slot 1 high time
- P2_PER, 1000: slot 2 period
- P2_HI, 500: slot 2 high time
- P3_PER, 100: reset value of the runtime slot 3 period
- P3_HI, 20: reset value of the runtime slot 3 high time

- clk_in  in  1  system clock; all logic on its rising edge
- rst_n  in  1  synchronous, active-low reset
- en  in  1  count enable; 0 freezes the divider
- sel  in  2  requested slot (0..3)
- load  in  1  write strobe for slot 3
- period_in  in  CNT_W  slot 3 period, captured when load=1
- high_in  in  CNT_W  slot 3 high time, captured when load=1
- clk_out  out  1  registered divided clock
- tick  out  1  one-cycle pulse on each period start (coincides with clk_out rising, or period start when high time is 0)
- sel_act  out  2  slot currently in effect

## Operation
- Internal state: cnt[CNT_W], active per_act/hi_act, sel_act, and slot 3 shadow registers per3/hi3.
- Reset (rst_n=0 at an edge): cnt=0, clk_out=0, tick=0, sel_act<=sel, per_act/hi_act loaded from slot sel (slot 3 uses P3_PER/P3_HI), per3=P3_PER, hi3=P3_HI.
- Enabled cycle: clk_out <= (cnt < hi_act); tick <= (cnt == 0); then cnt <= (cnt == per_act-1) ? 0 : cnt+1.
- Wrap (cnt == per_act-1 with en=1): sel_act <= sel, and per_act/hi_act are reloaded from slot sel. Slot 3 values are reloaded at every wrap, so a new load takes effect at the next boundary even when sel is unchanged.
- sel changes mid-period are ignored until the wrap. Multiple changes within one period: only the value present at the wrap counts.
- load=1: per3 <= max(period_in, 2); hi3 <= min(high_in, clamped period − 1).
  - A load in the same cycle as a wrap: the wrap uses the old per3/hi3; the new values apply at the following wrap.
- hi = 0 gives clk_out constantly 0, with tick still pulsing. Presets must satisfy 2 ≤ PER ≤ 2^CNT_W−1 and HI < PER; this is checked by elaboration-time assertion.
- en=0: cnt, clk_out, sel_act, per_act and hi_act hold. tick=0. load still works.
- Reset asserted mid-period aborts the period immediately; no completion is attempted.

## Timing
- Output latency: clk_out and tick reflect the cnt value of the previous cycle, a fixed 1-cycle lag.
- First enabled edge after reset release: clk_out=1, tick=1 (if hi_act>0).
- Each period is exactly per_act enabled cycles: hi_act cycles high, then per_act−hi_act cycles low.
- Switch latency: the new slot's first high phase begins 1 cycle after the wrap edge, with no extra cycles inserted.
- sel_act updates on the wrap edge, 1 cycle before the first tick of the new setting.
- Enable gaps stretch the current phase by the gap length. No phase is shortened.

## Test plan
- Override P0=10/2, P1=20/4, P2=7/3. Reset with sel=0, then en=1 -> clk_out repeats 2 high / 8 low, tick every 10 cycles aligned with rising clk_out, sel_act=0.
- Change sel 0→1 at cnt=4, back to 0 at cnt=6, then to 2 at cnt=8 -> period completes as 2/8, then sel_act=2 and 3 high / 4 low. No intermediate slot 1 period.
- sel=3 with default 100/20, then load period_in=1, high_in=5 -> clamped to 2/1 from the next wrap. Then load 50/0 -> clk_out stays 0 while tick pulses every 50 cycles.
- Load 30/6 on the exact wrap cycle while slot 3 is active -> one more 100/20 period, then 30/6.
- Deassert en for 5 cycles during a high phase -> high phase lasts 2+5 cycles, tick=0 throughout the gap, cnt resumes from its held value.
- Assert rst_n=0 at cnt=7 of slot 1, with sel=2 during reset -> next edge cnt=0 and clk_out=0; after release clk_out=1 immediately, sel_act=2, pattern 3/4.

Source files
------------

// File: rtl/prog_clk_div.sv
`default_nettype none
// ============================================================================
// Module   : prog_clk_div
// Purpose  : Glitch-free programmable clock divider with three preset slots
//            and one runtime-loadable slot; slot changes adopted at wrap.
// Revision : 1.0 - initial release
// ============================================================================
module prog_clk_div #(
    parameter int CNT_W  = 16,
    parameter int P0_PER = 4245,
    parameter int P0_HI  = 849,
    parameter int P1_PER = 28121,
    parameter int P1_HI  = 5625,
    parameter int P2_PER = 1000,
    parameter int P2_HI  = 500,
    parameter int P3_PER = 100,
    parameter int P3_HI  = 20
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       sel,
    input  logic             load,
    input  logic [CNT_W-1:0] period_in,
    input  logic [CNT_W-1:0] high_in,
    output logic             clk_out,
    output logic             tick,
    output logic [1:0]       sel_act
);

    function automatic bit preset_ok(input int per, input int hi);
        return (per >= 2) && (per <= (1 << CNT_W) - 1) && (hi >= 0) && (hi < per);
    endfunction

    localparam bit c_PRESETS_OK = preset_ok(P0_PER, P0_HI) && preset_ok(P1_PER, P1_HI) &&
                                  preset_ok(P2_PER, P2_HI) && preset_ok(P3_PER, P3_HI);

    if (!c_PRESETS_OK) begin : g_bad_preset
        $error("prog_clk_div: preset requires 2 <= PER <= 2^CNT_W-1 and HI < PER");
    end

    localparam logic [CNT_W-1:0] c_P0_PER = CNT_W'(P0_PER);
    localparam logic [CNT_W-1:0] c_P0_HI  = CNT_W'(P0_HI);
    localparam logic [CNT_W-1:0] c_P1_PER = CNT_W'(P1_PER);
    localparam logic [CNT_W-1:0] c_P1_HI  = CNT_W'(P1_HI);
    localparam logic [CNT_W-1:0] c_P2_PER = CNT_W'(P2_PER);
    localparam logic [CNT_W-1:0] c_P2_HI  = CNT_W'(P2_HI);
    localparam logic [CNT_W-1:0] c_P3_PER = CNT_W'(P3_PER);
    localparam logic [CNT_W-1:0] c_P3_HI  = CNT_W'(P3_HI);
    localparam logic [CNT_W-1:0] c_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_TWO    = CNT_W'(2);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_per_act;
    logic [CNT_W-1:0] r_hi_act;
    logic [CNT_W-1:0] r_per3;
    logic [CNT_W-1:0] r_hi3;
    logic [1:0]       r_sel_act;
    logic             r_clk_out;
    logic             r_tick;

    logic [CNT_W-1:0] w_nxt_per;
    logic [CNT_W-1:0] w_nxt_hi;
    logic [CNT_W-1:0] w_rst_per;
    logic [CNT_W-1:0] w_rst_hi;
    logic [CNT_W-1:0] w_ld_per;
    logic [CNT_W-1:0] w_ld_hi;
    logic             w_wrap;

    // Wrap reloads slot 3 from the shadow registers; reset uses the defaults.
    always_comb begin
        w_nxt_per = c_P0_PER;
        w_nxt_hi  = c_P0_HI;
        w_rst_per = c_P0_PER;
        w_rst_hi  = c_P0_HI;
        case (sel)
            2'd1: begin
                w_nxt_per = c_P1_PER;
                w_nxt_hi  = c_P1_HI;
                w_rst_per = c_P1_PER;
                w_rst_hi  = c_P1_HI;
            end
            2'd2: begin
                w_nxt_per = c_P2_PER;
                w_nxt_hi  = c_P2_HI;
                w_rst_per = c_P2_PER;
                w_rst_hi  = c_P2_HI;
            end
            2'd3: begin
                w_nxt_per = r_per3;
                w_nxt_hi  = r_hi3;
                w_rst_per = c_P3_PER;
                w_rst_hi  = c_P3_HI;
            end
            default: begin
                w_nxt_per = c_P0_PER;
                w_nxt_hi  = c_P0_HI;
            end
        endcase
    end

    assign w_ld_per = (period_in < c_TWO) ? c_TWO : period_in;
    assign w_ld_hi  = (high_in > (w_ld_per - c_ONE)) ? (w_ld_per - c_ONE) : high_in;
    assign w_wrap   = (r_cnt == (r_per_act - c_ONE));

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
            r_sel_act <= sel;
            r_per_act <= w_rst_per;
            r_hi_act  <= w_rst_hi;
            r_per3    <= c_P3_PER;
            r_hi3     <= c_P3_HI;
        end else begin
            if (en) begin
                r_clk_out <= (r_cnt < r_hi_act);
                r_tick    <= (r_cnt == '0);
                if (w_wrap) begin
                    r_cnt     <= '0;
                    r_sel_act <= sel;
                    r_per_act <= w_nxt_per;
                    r_hi_act  <= w_nxt_hi;
                end else begin
                    r_cnt <= r_cnt + c_ONE;
                end
            end else begin
                r_tick <= 1'b0;
            end
            if (load) begin
                r_per3 <= w_ld_per;
                r_hi3  <= w_ld_hi;
            end
        end
    end

    assign clk_out = r_clk_out;
    assign tick    = r_tick;
    assign sel_act = r_sel_act;

endmodule
`default_nettype wire

// File: tb/tb_prog_clk_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_clk_div
// Purpose  : Self-checking bench for prog_clk_div against a period/phase model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_clk_div;

    localparam int CNT_W = 16;
    localparam int PER_TAB [4] = '{10, 20, 7, 100};
    localparam int HI_TAB  [4] = '{2, 4, 3, 20};

    logic             clk_in = 1'b0;
    logic             rst_n;
    logic             en;
    logic [1:0]       sel;
    logic             load;
    logic [CNT_W-1:0] period_in;
    logic [CNT_W-1:0] high_in;
    logic             clk_out;
    logic             tick;
    logic [1:0]       sel_act;

    int n_vec = 0;
    int n_err = 0;

    // Model state: position inside the current period and the slot settings.
    int m_pos, m_per, m_hi, m_sel, m_per3, m_hi3;
    bit m_clk, m_tick;

    prog_clk_div #(
        .CNT_W (CNT_W),
        .P0_PER(10), .P0_HI(2),
        .P1_PER(20), .P1_HI(4),
        .P2_PER(7),  .P2_HI(3),
        .P3_PER(100), .P3_HI(20)
    ) u_dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .en       (en),
        .sel      (sel),
        .load     (load),
        .period_in(period_in),
        .high_in  (high_in),
        .clk_out  (clk_out),
        .tick     (tick),
        .sel_act  (sel_act)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int slot_per(input int s);
        return (s == 3) ? m_per3 : PER_TAB[s];
    endfunction

    function automatic int slot_hi(input int s);
        return (s == 3) ? m_hi3 : HI_TAB[s];
    endfunction

    // Advance the model by one clock edge using the currently applied inputs.
    task automatic model_step();
        int new_per3, new_hi3;
        new_per3 = m_per3;
        new_hi3  = m_hi3;
        if (!rst_n) begin
            m_pos  = 0;
            m_clk  = 0;
            m_tick = 0;
            m_sel  = int'(sel);
            m_per  = PER_TAB[sel];
            m_hi   = HI_TAB[sel];
            m_per3 = PER_TAB[3];
            m_hi3  = HI_TAB[3];
            return;
        end
        if (load) begin
            new_per3 = (int'(period_in) < 2) ? 2 : int'(period_in);
            new_hi3  = (int'(high_in) > new_per3 - 1) ? new_per3 - 1 : int'(high_in);
        end
        if (en) begin
            m_clk  = (m_pos < m_hi);
            m_tick = (m_pos == 0);
            m_pos  = (m_pos + 1) % m_per;
            if (m_pos == 0) begin
                m_sel = int'(sel);
                m_per = slot_per(m_sel);
                m_hi  = slot_hi(m_sel);
            end
        end else begin
            m_tick = 0;
        end
        m_per3 = new_per3;
        m_hi3  = new_hi3;
    endtask

    task automatic step_and_check(output bit hi, output bit tk);
        @(posedge clk_in);
        model_step();
        #1;
        check("clk_out", int'(clk_out), int'(m_clk));
        check("tick", int'(tick), int'(m_tick));
        check("sel_act", int'(sel_act), m_sel);
        hi = clk_out;
        tk = tick;
    endtask

    task automatic run(input int n, output int highs, output int ticks);
        bit hi, tk;
        highs = 0;
        ticks = 0;
        for (int i = 0; i < n; i++) begin
            step_and_check(hi, tk);
            highs += int'(hi);
            ticks += int'(tk);
            load = 1'b0;
        end
    endtask

    initial begin
        int highs, ticks;
        bit hi, tk;
        rst_n = 1'b0; en = 1'b0; sel = 2'd0; load = 1'b0;
        period_in = '0; high_in = '0;
        m_pos = 0; m_per = 10; m_hi = 2; m_sel = 0; m_per3 = 100; m_hi3 = 20;
        m_clk = 0; m_tick = 0;

        run(2, highs, ticks);
        check("rst_clk_out", int'(clk_out), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_sel_act", int'(sel_act), 0);

        // Slot 0: two full periods of 2 high / 8 low.
        rst_n = 1'b1; en = 1'b1;
        step_and_check(hi, tk);
        check("first_edge_clk", int'(hi), 1);
        check("first_edge_tick", int'(tk), 1);
        run(19, highs, ticks);
        check("p0_highs", highs + 1, 4);
        check("p0_ticks", ticks + 1, 2);

        // Switch to slot 3 and wait for it to be adopted, then load 1/5 (clamped 2/1).
        sel = 2'd3;
        run(15, highs, ticks);
        check("sel3_adopted", int'(sel_act), 3);
        load = 1'b1; period_in = 16'd1; high_in = 16'd5;
        run(110, highs, ticks);
        run(10, highs, ticks);
        check("clamp_highs", highs, 5);
        check("clamp_ticks", ticks, 5);

        // Load 50/0: clk_out stays low while tick keeps pulsing.
        load = 1'b1; period_in = 16'd50; high_in = 16'd0;
        run(4, highs, ticks);
        run(100, highs, ticks);
        check("hi0_highs", highs, 0);
        check("hi0_ticks", ticks, 2);

        // Enable gap stretches the phase; tick stays low throughout.
        sel = 2'd0;
        run(60, highs, ticks);
        en = 1'b0;
        run(5, highs, ticks);
        check("gap_ticks", ticks, 0);
        en = 1'b1;
        run(30, highs, ticks);

        // Randomized traffic with occasional resets, loads and enable gaps.
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            en    = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 29) == 0) sel = 2'($urandom_range(0, 3));
            load = ($urandom_range(0, 39) == 0);
            period_in = 16'($urandom_range(0, 40));
            high_in   = 16'($urandom_range(0, 45));
            step_and_check(hi, tk);
        end
        load = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
